// File: rtl/parity_step_counter.sv
// rtl/parity_step_counter.sv - odd/even step-by-2 up/down counter with load, limit flag and wrap pulse
// Optional ping-pong mode enabled by defining PARITY_STEP_COUNTER_BOUNCE_EN.
module parity_step_counter #(
    parameter int WIDTH  = 4,
    parameter int PARITY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             Y,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef PARITY_STEP_COUNTER_BOUNCE_EN
    input  logic             bounce,
`endif
    output logic [WIDTH-1:0] out,
    output logic             dir,
    output logic             at_limit,
    output logic             wrap
);

    localparam logic             PAR_BIT = (PARITY != 0);
    localparam logic [WIDTH-1:0] MIN_VAL = {{(WIDTH-1){1'b0}}, PAR_BIT};
    localparam logic [WIDTH-1:0] MAX_VAL = {{(WIDTH-1){1'b1}}, PAR_BIT};
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(2);

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             at_limit_q, at_limit_d;
    logic             wrap_q, wrap_d;
    logic             bounce_mode;

`ifdef PARITY_STEP_COUNTER_BOUNCE_EN
    assign bounce_mode = bounce;
`else
    assign bounce_mode = 1'b0;
`endif

    always_comb begin
        out_d  = out_q;
        dir_d  = Y;
        wrap_d = 1'b0;
        if (load) begin
            // LSB is coerced so the loaded value is always on the sequence
            out_d    = load_val;
            out_d[0] = PAR_BIT;
            dir_d    = Y;
        end else if (bounce_mode) begin
            // Ping-pong: direction is internal state, reflected at the limits
            dir_d = dir_q;
            if (en) begin
                if (dir_q) begin
                    if (out_q == MAX_VAL) begin
                        out_d  = MAX_VAL - STEP;
                        dir_d  = 1'b0;
                        wrap_d = 1'b1;
                    end else begin
                        out_d = out_q + STEP;
                    end
                end else begin
                    if (out_q == MIN_VAL) begin
                        out_d  = MIN_VAL + STEP;
                        dir_d  = 1'b1;
                        wrap_d = 1'b1;
                    end else begin
                        out_d = out_q - STEP;
                    end
                end
            end
        end else if (en) begin
            if (Y) begin
                if (out_q == MAX_VAL) begin
                    out_d  = MIN_VAL;
                    wrap_d = 1'b1;
                end else begin
                    out_d = out_q + STEP;
                end
            end else begin
                if (out_q == MIN_VAL) begin
                    out_d  = MAX_VAL;
                    wrap_d = 1'b1;
                end else begin
                    out_d = out_q - STEP;
                end
            end
        end
        at_limit_d = (out_d == MIN_VAL) || (out_d == MAX_VAL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= MIN_VAL;
            dir_q      <= 1'b1;
            at_limit_q <= 1'b1;
            wrap_q     <= 1'b0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            at_limit_q <= at_limit_d;
            wrap_q     <= wrap_d;
        end
    end

    assign out      = out_q;
    assign dir      = dir_q;
    assign at_limit = at_limit_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_parity_step_counter.sv
// tb/tb_parity_step_counter.sv - directed self-checking bench for parity_step_counter
module tb_parity_step_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: odd sequence
    logic       a_reset, a_en, a_y, a_load;
    logic [3:0] a_load_val;
    logic [3:0] a_out;
    logic       a_dir, a_at_limit, a_wrap;
`ifdef PARITY_STEP_COUNTER_BOUNCE_EN
    logic       a_bounce;
`endif

    // instance B: even sequence
    logic       b_reset, b_en, b_y, b_load;
    logic [3:0] b_load_val;
    logic [3:0] b_out;
    logic       b_dir, b_at_limit, b_wrap;
`ifdef PARITY_STEP_COUNTER_BOUNCE_EN
    logic       b_bounce;
`endif

    int checks = 0;
    int errors = 0;

    parity_step_counter #(.WIDTH(4), .PARITY(1)) u_odd (
        .clk      (clk),
        .reset    (a_reset),
        .en       (a_en),
        .Y        (a_y),
        .load     (a_load),
        .load_val (a_load_val),
`ifdef PARITY_STEP_COUNTER_BOUNCE_EN
        .bounce   (a_bounce),
`endif
        .out      (a_out),
        .dir      (a_dir),
        .at_limit (a_at_limit),
        .wrap     (a_wrap)
    );

    parity_step_counter #(.WIDTH(4), .PARITY(0)) u_even (
        .clk      (clk),
        .reset    (b_reset),
        .en       (b_en),
        .Y        (b_y),
        .load     (b_load),
        .load_val (b_load_val),
`ifdef PARITY_STEP_COUNTER_BOUNCE_EN
        .bounce   (b_bounce),
`endif
        .out      (b_out),
        .dir      (b_dir),
        .at_limit (b_at_limit),
        .wrap     (b_wrap)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_a(input string tag, input int o, input int l, input int w);
        check({tag, ".out"}, int'(a_out), o);
        check({tag, ".at_limit"}, int'(a_at_limit), l);
        check({tag, ".wrap"}, int'(a_wrap), w);
    endtask

    initial begin
        int exp_seq[8] = '{3, 5, 7, 9, 11, 13, 15, 1};
        a_reset = 1'b1; a_en = 1'b0; a_y = 1'b1; a_load = 1'b0; a_load_val = 4'd0;
        b_reset = 1'b1; b_en = 1'b0; b_y = 1'b1; b_load = 1'b0; b_load_val = 4'd0;
`ifdef PARITY_STEP_COUNTER_BOUNCE_EN
        a_bounce = 1'b0;
        b_bounce = 1'b0;
`endif
        @(negedge clk);
        step();
        check_a("t1_reset", 1, 1, 0);
        check("t1_reset.dir", int'(a_dir), 1);

        // up through the whole odd sequence and across the wrap
        a_reset = 1'b0; a_en = 1'b1; a_y = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_a($sformatf("t1_up%0d", i), exp_seq[i],
                    (exp_seq[i] == 15 || exp_seq[i] == 1) ? 1 : 0,
                    (exp_seq[i] == 1) ? 1 : 0);
        end

        // down across MIN, then hold
        a_y = 1'b0;
        step();
        check_a("t2_down_wrap", 15, 1, 1);
        check("t2_down_wrap.dir", int'(a_dir), 0);
        step();
        check_a("t2_down", 13, 0, 0);
        a_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_a($sformatf("t2_hold%0d", i), 13, 0, 0);
        end

        // load coerces LSB and overrides en; reset overrides load
        a_load = 1'b1; a_load_val = 4'd6; a_en = 1'b1; a_y = 1'b0;
        step();
        check_a("t3_load", 7, 0, 0);
        check("t3_load.dir", int'(a_dir), 0);
        a_reset = 1'b1;
        step();
        check_a("t3_reset_over_load", 1, 1, 0);
        check("t3_reset_over_load.dir", int'(a_dir), 1);

        // mid-count reset
        a_reset = 1'b0; a_load = 1'b0; a_y = 1'b1; a_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_a("t5_pre", 9, 0, 0);
        a_reset = 1'b1;
        step();
        check_a("t5_reset", 1, 1, 0);
        check("t5_reset.dir", int'(a_dir), 1);
        a_reset = 1'b0;
        step();
        check_a("t5_resume", 3, 0, 0);

        // even instance
        step();
        check("t4_reset.out", int'(b_out), 0);
        check("t4_reset.at_limit", int'(b_at_limit), 1);
        b_reset = 1'b0; b_load = 1'b1; b_load_val = 4'd12;
        step();
        check("t4_load12.out", int'(b_out), 12);
        b_load = 1'b0; b_en = 1'b1; b_y = 1'b1;
        step();
        check("t4_14.out", int'(b_out), 14);
        check("t4_14.at_limit", int'(b_at_limit), 1);
        check("t4_14.wrap", int'(b_wrap), 0);
        step();
        check("t4_0.out", int'(b_out), 0);
        check("t4_0.wrap", int'(b_wrap), 1);
        check("t4_0.at_limit", int'(b_at_limit), 1);
        b_load = 1'b1; b_load_val = 4'd9;
        step();
        check("t4_load9.out", int'(b_out), 8);
        check("t4_load9.wrap", int'(b_wrap), 0);

`ifdef PARITY_STEP_COUNTER_BOUNCE_EN
        // ping-pong: Y toggled every edge must not matter
        a_load = 1'b1; a_load_val = 4'd13; a_y = 1'b1; a_en = 1'b1; a_bounce = 1'b0;
        step();
        check_a("t6_load", 13, 0, 0);
        a_load = 1'b0; a_bounce = 1'b1;
        begin
            int bo[9] = '{15, 13, 11, 9, 7, 5, 3, 1, 3};
            int bd[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
            int bw[9] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
            for (int i = 0; i < 9; i++) begin
                a_y = ~a_y;
                step();
                check_a($sformatf("t6_b%0d", i), bo[i],
                        (bo[i] == 15 || bo[i] == 1) ? 1 : 0, bw[i]);
                check($sformatf("t6_b%0d.dir", i), int'(a_dir), bd[i]);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
